// File: rtl/sum_differencer_pkg.sv
// sum_pkg: shared widths and ramp-checker state encoding for the sum differencer.
//   SUM_W_DEF - default width of the incoming running sum
//   IN_W_DEF  - default width of a recovered sample
//   ERR_W_DEF - default width of the saturating sequence-error counter
//   chk_state_e - ramp checker states (hunt, track, fault)
package sum_pkg;

    localparam int unsigned SUM_W_DEF = 11;
    localparam int unsigned IN_W_DEF  = 5;
    localparam int unsigned ERR_W_DEF = 8;

    typedef enum logic [1:0] {
        StHunt  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sum_differencer_ramp_checker.sv
// ramp_checker: checks recovered samples against an incrementing ramp.
// Steps once per strobe. It locks on the first sample after reset, counts a
// mismatch (saturating) and drops to fault, then resyncs on the next sample.
//   clk           - clock, rising edge
//   resetn        - synchronous active-low reset
//   step_i        - a new sample is available this cycle
//   s_i           - the new sample
//   range_err_i   - the new sample overflowed its width
//   locked_o      - checker is tracking the ramp (registered)
//   seq_err_cnt_o - saturating count of ramp mismatches
module ramp_checker
    import sum_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step_i,
    input  logic [IN_W-1:0]  s_i,
    input  logic             range_err_i,
    output logic             locked_o,
    output logic [ERR_W-1:0] seq_err_cnt_o
);

    chk_state_e       state_q;
    logic [IN_W-1:0]  ref_q;
    logic [IN_W-1:0]  ref_inc;
    logic             locked_q;
    logic [ERR_W-1:0] cnt_q;

    // Ramp expectation wraps modulo 2^IN_W.
    assign ref_inc = ref_q + IN_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StHunt;
            ref_q    <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else if (step_i) begin
            case (state_q)
                // Hunt and fault both adopt the current sample as the new reference.
                StHunt, StFault: begin
                    ref_q    <= s_i;
                    state_q  <= StTrack;
                    locked_q <= 1'b1;
                end
                StTrack: begin
                    if ((s_i == ref_inc) && !range_err_i) begin
                        ref_q <= s_i;
                    end else begin
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + ERR_W'(1);
                        end
                        state_q  <= StFault;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StHunt;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked_o      = locked_q;
    assign seq_err_cnt_o = cnt_q;

endmodule

// File: rtl/sum_differencer.sv
// sum_differencer: recovers per-cycle samples from a running-sum stream as
// sum[n] - sum[n-1] (mod 2^SUM_W) and checks them against an incrementing ramp.
//   clk           - clock, rising edge
//   resetn        - synchronous active-low reset
//   sum_in        - running-sum beat
//   sum_valid     - sum_in valid
//   sum_ready     - a beat is accepted this cycle when sum_valid is also high
//   smp_out       - recovered sample (low IN_W bits of the difference)
//   smp_range_err - difference did not fit in IN_W bits
//   smp_valid     - smp_out valid
//   smp_ready     - downstream accepts the sample
//   locked        - ramp checker is tracking
//   seq_err_cnt   - saturating count of ramp mismatches
module sum_differencer
    import sum_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic [IN_W-1:0]  smp_out,
    output logic             smp_range_err,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic             locked,
    output logic [ERR_W-1:0] seq_err_cnt
);

    logic [SUM_W-1:0] prev_sum_q;
    logic [SUM_W-1:0] diff;
    logic [IN_W-1:0]  smp_q;
    logic             range_err_q;
    logic             valid_q;
    logic             accept;
    logic             diff_range_err;

    // Single output register, no skid: accept whenever the slot is free or draining.
    assign sum_ready = !valid_q || smp_ready;
    assign accept    = sum_valid && sum_ready;

    // Modular subtraction recovers the sample even when the sum wraps.
    assign diff           = sum_in - prev_sum_q;
    assign diff_range_err = |diff[SUM_W-1:IN_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_sum_q  <= '0;
            smp_q       <= '0;
            range_err_q <= 1'b0;
            valid_q     <= 1'b0;
        end else if (accept) begin
            prev_sum_q  <= sum_in;
            smp_q       <= diff[IN_W-1:0];
            range_err_q <= diff_range_err;
            valid_q     <= 1'b1;
        end else if (smp_ready) begin
            valid_q <= 1'b0;
        end
    end

    ramp_checker #(
        .IN_W  (IN_W),
        .ERR_W (ERR_W)
    ) u_ramp_checker (
        .clk           (clk),
        .resetn        (resetn),
        .step_i        (accept),
        .s_i           (diff[IN_W-1:0]),
        .range_err_i   (diff_range_err),
        .locked_o      (locked),
        .seq_err_cnt_o (seq_err_cnt)
    );

    assign smp_out       = smp_q;
    assign smp_range_err = range_err_q;
    assign smp_valid     = valid_q;

endmodule

// File: tb/tb_sum_differencer.sv
module tb_sum_differencer;

    localparam int unsigned SUM_W = 11;
    localparam int unsigned IN_W  = 5;
    localparam int unsigned ERR_W = 8;

    logic             clk;
    logic             resetn;
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             sum_ready;
    logic [IN_W-1:0]  smp_out;
    logic             smp_range_err;
    logic             smp_valid;
    logic             smp_ready;
    logic             locked;
    logic [ERR_W-1:0] seq_err_cnt;

    // Second instance with a narrow error counter for saturation.
    logic [SUM_W-1:0] sum_in2;
    logic             sum_valid2;
    logic             sum_ready2;
    logic [IN_W-1:0]  smp_out2;
    logic             smp_range_err2;
    logic             smp_valid2;
    logic             locked2;
    logic [1:0]       seq_err_cnt2;

    int n_cmp;
    int n_bad;

    sum_differencer #(
        .SUM_W (SUM_W),
        .IN_W  (IN_W),
        .ERR_W (ERR_W)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .sum_in        (sum_in),
        .sum_valid     (sum_valid),
        .sum_ready     (sum_ready),
        .smp_out       (smp_out),
        .smp_range_err (smp_range_err),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .locked        (locked),
        .seq_err_cnt   (seq_err_cnt)
    );

    sum_differencer #(
        .SUM_W (SUM_W),
        .IN_W  (IN_W),
        .ERR_W (2)
    ) u_dut2 (
        .clk           (clk),
        .resetn        (resetn),
        .sum_in        (sum_in2),
        .sum_valid     (sum_valid2),
        .sum_ready     (sum_ready2),
        .smp_out       (smp_out2),
        .smp_range_err (smp_range_err2),
        .smp_valid     (smp_valid2),
        .smp_ready     (1'b1),
        .locked        (locked2),
        .seq_err_cnt   (seq_err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        sum_valid = 1'b0;
        sum_in    = '0;
        smp_ready = 1'b1;
        sum_valid2 = 1'b0;
        sum_in2    = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic beat(input logic [SUM_W-1:0] s);
        sum_in    = s;
        sum_valid = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({smp_valid, smp_out, smp_range_err, locked, seq_err_cnt, sum_ready} !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%0b out=%0d rerr=%0b lock=%0b cnt=%0d rdy=%0b want 0,0,0,0,0,1",
                     smp_valid, smp_out, smp_range_err, locked, seq_err_cnt, sum_ready);
        end
    endtask

    task automatic test_ramp();
        logic [SUM_W-1:0] acc;
        logic [IN_W-1:0]  exp_s;
        do_reset();
        acc = '0;
        for (int i = 0; i < 260; i++) begin
            exp_s = IN_W'(i % 32);
            acc   = acc + SUM_W'(i % 32);
            beat(acc);
            n_cmp++;
            if (smp_out !== exp_s || smp_valid !== 1'b1 || smp_range_err !== 1'b0) begin
                n_bad++;
                $display("FAIL ramp_sample[%0d]: got out=%0d v=%0b rerr=%0b want out=%0d v=1 rerr=0",
                         i, smp_out, smp_valid, smp_range_err, exp_s);
            end
            if (i >= 1) begin
                n_cmp++;
                if (locked !== 1'b1 || seq_err_cnt !== '0) begin
                    n_bad++;
                    $display("FAIL ramp_lock[%0d]: got lock=%0b cnt=%0d want lock=1 cnt=0",
                             i, locked, seq_err_cnt);
                end
            end
        end
        sum_valid = 1'b0;
        step();
        n_cmp++;
        if (smp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_drain: got valid=%0b want 0", smp_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        beat(11'd2040);
        beat(11'd3);
        n_cmp++;
        if (smp_out !== 5'd11 || smp_range_err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap: got out=%0d rerr=%0b want out=11 rerr=0", smp_out, smp_range_err);
        end
    endtask

    task automatic test_range_err();
        do_reset();
        beat(11'd0);
        beat(11'd40);
        n_cmp++;
        if (smp_out !== 5'd8 || smp_range_err !== 1'b1 || smp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL range_err_data: got out=%0d rerr=%0b v=%0b want out=8 rerr=1 v=1",
                     smp_out, smp_range_err, smp_valid);
        end
        n_cmp++;
        if (seq_err_cnt !== 8'd1 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL range_err_chk: got cnt=%0d lock=%0b want cnt=1 lock=0",
                     seq_err_cnt, locked);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        smp_ready = 1'b0;
        beat(11'd1);
        n_cmp++;
        if (smp_out !== 5'd1 || smp_valid !== 1'b1 || sum_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_first: got out=%0d v=%0b rdy=%0b want out=1 v=1 rdy=0",
                     smp_out, smp_valid, sum_ready);
        end
        sum_in = 11'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (smp_out !== 5'd1 || smp_valid !== 1'b1 || sum_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got out=%0d v=%0b rdy=%0b want out=1 v=1 rdy=0",
                         i, smp_out, smp_valid, sum_ready);
            end
        end
        smp_ready = 1'b1;
        #1;
        n_cmp++;
        if (sum_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready_comb: got rdy=%0b want 1", sum_ready);
        end
        beat(11'd3);
        n_cmp++;
        if (smp_out !== 5'd2) begin
            n_bad++;
            $display("FAIL bp_resume2: got out=%0d want 2", smp_out);
        end
        beat(11'd6);
        n_cmp++;
        if (smp_out !== 5'd3) begin
            n_bad++;
            $display("FAIL bp_resume3: got out=%0d want 3", smp_out);
        end
        beat(11'd10);
        n_cmp++;
        if (smp_out !== 5'd4 || locked !== 1'b1 || seq_err_cnt !== '0) begin
            n_bad++;
            $display("FAIL bp_resume4: got out=%0d lock=%0b cnt=%0d want out=4 lock=1 cnt=0",
                     smp_out, locked, seq_err_cnt);
        end
        sum_valid = 1'b0;
        step();
        n_cmp++;
        if (smp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_clear: got v=%0b want 0", smp_valid);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        beat(11'd5);
        beat(11'd11);
        n_cmp++;
        if (smp_out !== 5'd6 || locked !== 1'b1 || seq_err_cnt !== '0) begin
            n_bad++;
            $display("FAIL glitch_6: got out=%0d lock=%0b cnt=%0d want out=6 lock=1 cnt=0",
                     smp_out, locked, seq_err_cnt);
        end
        beat(11'd20);
        n_cmp++;
        if (smp_out !== 5'd9 || locked !== 1'b0 || seq_err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL glitch_9: got out=%0d lock=%0b cnt=%0d want out=9 lock=0 cnt=1",
                     smp_out, locked, seq_err_cnt);
        end
        beat(11'd30);
        n_cmp++;
        if (smp_out !== 5'd10 || locked !== 1'b1 || seq_err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL glitch_10: got out=%0d lock=%0b cnt=%0d want out=10 lock=1 cnt=1",
                     smp_out, locked, seq_err_cnt);
        end
        beat(11'd41);
        n_cmp++;
        if (smp_out !== 5'd11 || locked !== 1'b1 || seq_err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL glitch_11: got out=%0d lock=%0b cnt=%0d want out=11 lock=1 cnt=1",
                     smp_out, locked, seq_err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        // Samples 0 then a constant 10: every other beat mismatches (5 errors in total).
        for (int i = 0; i <= 10; i++) begin
            sum_in2    = SUM_W'(10 * i);
            sum_valid2 = 1'b1;
            step();
            if (i == 4) begin
                n_cmp++;
                if (seq_err_cnt2 !== 2'd2) begin
                    n_bad++;
                    $display("FAIL sat_mid: got cnt=%0d want 2", seq_err_cnt2);
                end
            end
        end
        sum_valid2 = 1'b0;
        n_cmp++;
        if (seq_err_cnt2 !== 2'd3 || smp_out2 !== 5'd10) begin
            n_bad++;
            $display("FAIL sat_final: got cnt=%0d out=%0d want cnt=3 out=10", seq_err_cnt2, smp_out2);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        beat(11'd0);
        beat(11'd1);
        beat(11'd6);
        n_cmp++;
        if (seq_err_cnt !== 8'd1 || smp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got cnt=%0d v=%0b want cnt=1 v=1", seq_err_cnt, smp_valid);
        end
        resetn = 1'b0;
        sum_in = 11'd9;
        step();
        n_cmp++;
        if (smp_valid !== 1'b0 || locked !== 1'b0 || seq_err_cnt !== '0 || smp_out !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%0b lock=%0b cnt=%0d out=%0d want 0,0,0,0",
                     smp_valid, locked, seq_err_cnt, smp_out);
        end
        resetn = 1'b1;
        beat(11'd7);
        n_cmp++;
        if (smp_out !== 5'd7 || smp_range_err !== 1'b0 || smp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_after: got out=%0d rerr=%0b v=%0b want out=7 rerr=0 v=1",
                     smp_out, smp_range_err, smp_valid);
        end
        sum_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        resetn     = 1'b0;
        sum_in     = '0;
        sum_valid  = 1'b0;
        smp_ready  = 1'b1;
        sum_in2    = '0;
        sum_valid2 = 1'b0;
        test_reset();
        test_ramp();
        test_wrap();
        test_range_err();
        test_backpressure();
        test_glitch();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_differencer.md
Name: sum_differencer

Overview:
- Inverse end of the accumulator path: consumes the running-sum stream that the accumulator produces and recovers the original per-cycle samples as sum[n] - sum[n-1], modulo 2^SUM_W.
- Checks each recovered sample against an incrementing-ramp expectation, which matches the counter stimulus used on the accumulator side.
- Sits after the accumulator in simulation and FPGA loopback tests, so the sum stream can be verified in hardware without file dumps.

Parameters:
- SUM_W, 11, width of the incoming running sum.
- IN_W, 5, width of the recovered sample.
- ERR_W, 8, width of the saturating sequence-error counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- sum_in  in  SUM_W  running-sum beat.
- sum_valid  in  1  sum_in valid.
- sum_ready  out  1  block accepts a sum beat this cycle.
- smp_out  out  IN_W  recovered sample.
- smp_range_err  out  1  qualifies smp_out: the difference did not fit in IN_W bits.
- smp_valid  out  1  smp_out valid.
- smp_ready  in  1  downstream accepts the sample.
- locked  out  1  ramp checker is in TRACK.
- seq_err_cnt  out  ERR_W  saturating count of ramp mismatches.

Behaviour:
- Clock and reset: clk; reset resetn, synchronous, active-low.
- Reset values: smp_out=0, smp_range_err=0, smp_valid=0, locked=0, seq_err_cnt=0, prev_sum=0, checker state=HUNT.
- Input accept: a beat is accepted when sum_valid && sum_ready.
  - sum_ready = !smp_valid || smp_ready, a single output register with no skid.
  - sum_ready is combinational from smp_ready.
- Latency: an accepted beat in cycle t appears on smp_out with smp_valid=1 in cycle t+1.
- Output hold: smp_out and smp_range_err stay stable while smp_valid && !smp_ready.
- Difference arithmetic, on accept:
  - diff = (sum_in - prev_sum) mod 2^SUM_W, unsigned.
  - smp_out <= diff[IN_W-1:0].
  - smp_range_err <= |diff[SUM_W-1:IN_W].
  - prev_sum <= sum_in.
- First beat after reset: differenced against prev_sum=0. This matches an accumulator that resets to 0.
- Wrap-around: a sum that wraps through 2^SUM_W still yields the correct small diff, because the subtraction is modular. Example: prev=2040, sum_in=3 gives diff=11.
- Output clear: smp_valid clears when smp_ready=1 and no new beat is accepted in the same cycle. A simultaneous drain and accept keeps smp_valid=1 and loads the new sample.
- Ramp checker: steps once per accepted beat, using the newly computed sample s. ref is an internal IN_W-bit register.
  - HUNT: ref <= s, go to TRACK.
  - TRACK, s == ref+1 (mod 2^IN_W) and no range error: ref <= s, stay in TRACK.
  - TRACK, otherwise: seq_err_cnt += 1 (saturating at all-ones), go to FAULT.
  - FAULT: ref <= s, go to TRACK. Exactly one beat is consumed to resync.
- locked = (state == TRACK), registered.
- Range-error beats are still forwarded downstream, with the flag set.
- Reset mid-stream: takes effect on the next edge. Any pending output is dropped, prev_sum returns to 0, and the checker restarts in HUNT.
- sum_in is ignored when sum_valid=0. prev_sum updates only on accept.

Decomposition:
- Shared package sum_pkg holds:
  - default widths SUM_W_DEF=11, IN_W_DEF=5, ERR_W_DEF=8;
  - checker state enum {HUNT, TRACK, FAULT}.
- One natural sub-module: ramp_checker. It takes s, a step strobe and the range flag, and produces locked and seq_err_cnt.
- The differencer datapath and the handshake stay in the top.

Test Plan:
- Ramp loopback: feed the running sums of 0,1,2,…,31,0,1… (0,1,3,6,10,…) with sum_valid=1 and smp_ready=1.
  - smp_out equals the ramp, delayed 1 cycle.
  - locked=1 from the second sample onward.
  - seq_err_cnt stays 0.
  - Run for more than 200 beats so the sum wraps past 2047.
- Wrap: sum_in 2040 then 3 → second smp_out=11, smp_range_err=0.
- Range error: sum_in 0 then 40 → smp_out=8 (40 mod 32), smp_range_err=1, seq_err_cnt=1, and the checker passes through FAULT.
- Backpressure: hold smp_ready=0 for 3 cycles while sum_valid=1.
  - sum_ready=0 after the first accept.
  - smp_out is held stable.
  - No beats are lost or duplicated when smp_ready returns to 1.
- Sequence glitch: ramp 5,6,9,10,11.
  - seq_err_cnt becomes 1 at 9.
  - The checker resyncs on 10 and is locked again at 11.
  - Saturation check: force ERR_W=2 with repeated glitches → the counter stops at 3.
- Reset mid-stream: assert resetn=0 for 1 cycle during a ramp.
  - smp_valid=0, locked=0, seq_err_cnt=0.
  - The next sum differences against 0.
